// File: rtl/izero_pkg.sv
// rtl/izero_pkg.sv - shared encodings and defaults for the izero processor PC stage
package izero_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 10;

    // Sequencer states of the program-counter stage
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_IN = 2'd1,
        HALTED  = 2'd2
    } pc_state_e;

    // Next-PC source selected by the control-unit decoder
    typedef enum logic [1:0] {
        PC_NEXT   = 2'b00,
        PC_BRANCH = 2'b01,
        PC_REG    = 2'b10,
        PC_JUMP   = 2'b11
    } pc_src_e;

endpackage

// File: rtl/unidade_pc_if.sv
// rtl/unidade_pc_if.sv - decoder/PC-stage bundle; userLimit and fault exist only with UNIDADE_PC_BOUNDS_EN
interface unidade_pc_if
    import izero_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);
    logic [1:0]            pcSource;
    logic                  isHalt;
    logic                  isInsert;
    logic                  confirmKey;
    logic                  userMode;
    logic                  kernelMode;
    logic [ADDR_WIDTH-1:0] branchTarget;
    logic [ADDR_WIDTH-1:0] regTarget;
    logic [ADDR_WIDTH-1:0] jumpTarget;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pcPlus1;
    logic [ADDR_WIDTH-1:0] epc;
    logic                  isUser;
    logic                  stall;
    logic                  halted;
`ifdef UNIDADE_PC_BOUNDS_EN
    logic [ADDR_WIDTH-1:0] userLimit;
    logic                  fault;
`endif

    // Decoder / datapath side
    modport master (
        output pcSource, isHalt, isInsert, confirmKey, userMode, kernelMode,
        output branchTarget, regTarget, jumpTarget,
`ifdef UNIDADE_PC_BOUNDS_EN
        output userLimit,
        input  fault,
`endif
        input  pc, pcPlus1, epc, isUser, stall, halted
    );

    // Program-counter stage side
    modport slave (
        input  pcSource, isHalt, isInsert, confirmKey, userMode, kernelMode,
        input  branchTarget, regTarget, jumpTarget,
`ifdef UNIDADE_PC_BOUNDS_EN
        input  userLimit,
        output fault,
`endif
        output pc, pcPlus1, epc, isUser, stall, halted
    );
endinterface

// File: rtl/detector_borda.sv
// rtl/detector_borda.sv - registered rising-edge detector with configurable reset level
module detector_borda #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);
    logic level_q;

    // Remember last cycle's level; resetting to 1 masks a level already high at reset
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= RESET_VALUE;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;
endmodule

// File: rtl/unidade_pc.sv
// rtl/unidade_pc.sv - PC, mode/epc and RUN/WAIT_IN/HALTED sequencer; optional user bounds trap via UNIDADE_PC_BOUNDS_EN
module unidade_pc
    import izero_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
`ifdef UNIDADE_PC_BOUNDS_EN
    ,
    parameter logic [ADDR_WIDTH-1:0] KERNEL_VECTOR = '0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    unidade_pc_if.slave bus
);
    pc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic                  is_user_q, is_user_d;
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  confirm_rise;
    logic                  stall;
`ifdef UNIDADE_PC_BOUNDS_EN
    logic                  fault_q, fault_d;
`endif

    // Key held through reset must not look like a press, so the history resets high
    detector_borda #(
        .RESET_VALUE (1'b1)
    ) u_confirm (
        .clk     (clk),
        .reset   (reset),
        .level_i (bus.confirmKey),
        .rise_o  (confirm_rise)
    );

    assign pc_plus1 = pc_q + ADDR_WIDTH'(1);

    // Next-PC selection from the decoder's pcSource
    always_comb begin
        next_pc = pc_plus1;
        case (pc_src_e'(bus.pcSource))
            PC_NEXT:   next_pc = pc_plus1;
            PC_BRANCH: next_pc = bus.branchTarget;
            PC_REG:    next_pc = bus.regTarget;
            PC_JUMP:   next_pc = bus.jumpTarget;
            default:   next_pc = pc_plus1;
        endcase
    end

    // Sequencer next state, PC/mode/epc updates and stall
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        is_user_d = is_user_q;
        stall     = 1'b1;
`ifdef UNIDADE_PC_BOUNDS_EN
        fault_d   = 1'b0;
`endif
        case (state_q)
            RUN: begin
                if (bus.isHalt) begin
                    state_d = HALTED;
                end else if (bus.isInsert) begin
                    state_d = WAIT_IN;
                end else begin
                    stall = 1'b0;
                    pc_d  = next_pc;
                    if (bus.kernelMode) begin
                        is_user_d = 1'b0;
                        epc_d     = pc_plus1;
                    end else if (bus.userMode) begin
                        is_user_d = 1'b1;
                    end
`ifdef UNIDADE_PC_BOUNDS_EN
                    // Checked against the mode this instruction leaves us in
                    if (is_user_d && (next_pc > bus.userLimit)) begin
                        pc_d      = KERNEL_VECTOR;
                        is_user_d = 1'b0;
                        epc_d     = pc_q;
                        fault_d   = 1'b1;
                    end
`endif
                end
            end
            WAIT_IN: begin
                // The in-instruction commits only on the cycle the key rises
                stall = ~confirm_rise;
                if (confirm_rise) begin
                    pc_d    = pc_plus1;
                    state_d = RUN;
                end
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_VECTOR;
            epc_q     <= '0;
            is_user_q <= 1'b0;
`ifdef UNIDADE_PC_BOUNDS_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            is_user_q <= is_user_d;
`ifdef UNIDADE_PC_BOUNDS_EN
            fault_q   <= fault_d;
`endif
        end
    end

    assign bus.pc      = pc_q;
    assign bus.pcPlus1 = pc_plus1;
    assign bus.epc     = epc_q;
    assign bus.isUser  = is_user_q;
    assign bus.stall   = stall;
    assign bus.halted  = (state_q == HALTED);
`ifdef UNIDADE_PC_BOUNDS_EN
    assign bus.fault   = fault_q;
`endif
endmodule

// File: tb/tb_unidade_pc.sv
// tb/tb_unidade_pc.sv - scoreboard bench for unidade_pc against a behavioural model
module tb_unidade_pc;
    localparam int AW = 10;
    localparam logic [AW-1:0] RV = 10'h000;
    localparam logic [AW-1:0] KV = 10'h000;

    typedef struct {
        bit            chk_comb;
        bit            stall;
        logic [AW-1:0] pcp1;
        logic [AW-1:0] pc;
        logic [AW-1:0] epc;
        bit            user;
        bit            halted;
        bit            fault;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   drv_done = 1'b0;
    exp_t sb[$];

    unidade_pc_if #(.ADDR_WIDTH(AW)) bus ();

    unidade_pc #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: 0 running, 1 waiting for key, 2 halted
    logic [AW-1:0] m_pc, m_epc;
    bit            m_user, m_prev, m_init;
    int            m_mode;

    task automatic step(input bit rst, input logic [1:0] src, input bit halt, input bit ins,
                        input bit key, input bit um, input bit km,
                        input logic [AW-1:0] bt, input logic [AW-1:0] rt,
                        input logic [AW-1:0] jt, input logic [AW-1:0] lim);
        exp_t          e;
        bit            rise;
        logic [AW-1:0] npc;
        reset            = rst;
        bus.pcSource     = src;
        bus.isHalt       = halt;
        bus.isInsert     = ins;
        bus.confirmKey   = key;
        bus.userMode     = um;
        bus.kernelMode   = km;
        bus.branchTarget = bt;
        bus.regTarget    = rt;
        bus.jumpTarget   = jt;
`ifdef UNIDADE_PC_BOUNDS_EN
        bus.userLimit    = lim;
`endif
        rise       = key && !m_prev;
        e.chk_comb = m_init && !rst;
        e.pcp1     = m_pc + 1'b1;
        e.fault    = 1'b0;
        if (m_mode == 0)      e.stall = halt || ins;
        else if (m_mode == 1) e.stall = !rise;
        else                  e.stall = 1'b1;
        if (rst) begin
            m_pc = RV; m_mode = 0; m_user = 0; m_epc = '0; m_prev = 1'b1; m_init = 1'b1;
        end else begin
            m_prev = key;
            if (m_mode == 0) begin
                if (halt)      m_mode = 2;
                else if (ins)  m_mode = 1;
                else begin
                    npc = (src == 2'd0) ? m_pc + 1'b1 : (src == 2'd1) ? bt : (src == 2'd2) ? rt : jt;
                    if (km) begin m_user = 0; m_epc = m_pc + 1'b1; end
                    else if (um) m_user = 1;
`ifdef UNIDADE_PC_BOUNDS_EN
                    if (m_user && npc > lim) begin
                        npc = KV; m_user = 0; m_epc = m_pc; e.fault = 1'b1;
                    end
`endif
                    m_pc = npc;
                end
            end else if (m_mode == 1 && rise) begin
                m_pc = m_pc + 1'b1; m_mode = 0;
            end
        end
        e.pc     = m_pc;
        e.epc    = m_epc;
        e.user   = m_user;
        e.halted = (m_mode == 2);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] src);
        step(0, src, 0, 0, 0, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
    endtask

    task automatic jump(input logic [AW-1:0] t, input bit um, input bit km);
        step(0, 2'd3, 0, 0, 0, um, km, 10'h0, 10'h0, t, 10'h1FF);
    endtask

    task automatic rst_cyc(input bit key);
        step(1, 2'd0, 0, 0, key, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk_comb) begin
                    chk("stall", 32'(bus.stall), 32'(e.stall));
                    chk("pcPlus1", 32'(bus.pcPlus1), 32'(e.pcp1));
                end
                @(posedge clk);
                #1;
                chk("pc", 32'(bus.pc), 32'(e.pc));
                chk("epc", 32'(bus.epc), 32'(e.epc));
                chk("isUser", 32'(bus.isUser), 32'(e.user));
                chk("halted", 32'(bus.halted), 32'(e.halted));
`ifdef UNIDADE_PC_BOUNDS_EN
                chk("fault", 32'(bus.fault), 32'(e.fault));
`endif
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        m_pc = '0; m_epc = '0; m_user = 0; m_prev = 1; m_init = 0; m_mode = 0;
        @(negedge clk);
        rst_cyc(0);
        rst_cyc(0);
        repeat (4) run(2'd0);
        jump(10'h3FF, 0, 0);
        run(2'd0);
        jump(10'h02A, 0, 0);
        run(2'd0);
        jump(10'h005, 0, 0);
        step(0, 2'd0, 0, 1, 0, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
        repeat (10) run(2'd0);
        step(0, 2'd0, 0, 0, 1, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
        step(0, 2'd0, 0, 0, 1, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
        rst_cyc(1);
        rst_cyc(1);
        step(0, 2'd0, 0, 1, 1, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
        repeat (3) step(0, 2'd0, 0, 0, 1, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
        run(2'd0);
        step(0, 2'd0, 0, 0, 1, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
        run(2'd0);
        jump(10'h010, 0, 0);
        step(0, 2'd2, 0, 0, 0, 0, 1, 10'h0, 10'h080, 10'h0, 10'h1FF);
        jump(10'h100, 1, 0);
        step(0, 2'd0, 1, 0, 0, 0, 0, 10'h0, 10'h0, 10'h0, 10'h1FF);
        repeat (20) step(0, 2'd3, 0, 0, 0, 1, 1, 10'h0, 10'h0, 10'h055, 10'h1FF);
        rst_cyc(0);
        step(0, 2'd1, 0, 0, 0, 1, 1, 10'h0AA, 10'h0, 10'h0, 10'h1FF);
        jump(10'h1FF, 1, 0);
        run(2'd0);
        run(2'd0);
        run(2'd0);
        rst_cyc(0);
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 60) == 0, 2'($urandom), ($urandom % 40) == 0, ($urandom % 8) == 0,
                 ($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
                 10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom_range(10'h3FF, 10'h100)));
        end
        drv_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report
    initial begin
        int guard = 0;
        wait (drv_done);
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
